// File: rtl/fn_sw_pipe.sv
// Two-stage pipelined bitwise function unit: 8 selectable logic functions on WIDTH-bit
// operands, with an optional accumulator standing in for operand A.
module fn_sw_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             acc_en,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_par,
    output logic [CNT_W-1:0] op_cnt
);

    // Handshake: a beat moves on valid & ready. Stage 2 advances when empty or drained
    // (advance2), stage 1 moves into stage 2 when full and stage 2 advances (advance1),
    // and the input side is ready whenever stage 1 is empty or is being emptied.
    logic             s1_v;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_sel;
    logic             s1_acc_en;
    logic             s2_v;
    logic [WIDTH-1:0] acc;

    logic             advance1;
    logic             advance2;
    logic             accept;
    logic             fire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    assign advance2  = !s2_v || out_ready;
    assign advance1  = s1_v && advance2;
    assign in_ready  = !s1_v || advance2;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v;
    assign fire      = s2_v && out_ready;

    // The accumulator is read only at the s1->s2 transfer, so chained accumulate ops see
    // the value written by the previous transfer without any forwarding.
    always_comb begin
        op_a   = s1_acc_en ? acc : s1_a;
        result = '0;
        case (s1_sel)
            3'b000:  result = op_a & s1_b;
            3'b001:  result = op_a | s1_b;
            3'b010:  result = op_a ^ s1_b;
            3'b011:  result = ~(op_a ^ s1_b);
            3'b100:  result = ~(op_a & s1_b);
            3'b101:  result = ~(op_a | s1_b);
            3'b110:  result = op_a & ~s1_b;
            default: result = op_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= '0;
            s1_acc_en <= 1'b0;
        end else if (accept) begin
            s1_v      <= 1'b1;
            s1_a      <= a;
            s1_b      <= b;
            s1_sel    <= sel;
            s1_acc_en <= acc_en;
        end else if (advance1) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v   <= 1'b0;
            y      <= '0;
            y_zero <= 1'b1;
            y_par  <= 1'b0;
        end else if (advance2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                y      <= result;
                y_zero <= (result == '0);
                y_par  <= ^result;
            end
        end
    end

    // A clear in the same cycle as an accumulate transfer wins over the write-back.
    always_ff @(posedge clk) begin
        if (rst || clr_acc) begin
            acc <= '0;
        end else if (advance1 && s1_acc_en) begin
            acc <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (fire) begin
            op_cnt <= op_cnt + 1'b1;
        end
    end

endmodule

// File: doc/fn_sw_pipe.md
Name: fn_sw_pipe

Overview:
- Parametrised, pipelined successor to the 1-bit 4-function logic switch.
- Applies one of 8 bitwise functions to WIDTH-bit operands a and b, selected per transaction by sel.
- Optional accumulate mode replaces operand a with an internal accumulator.
- Two register stages with valid/ready handshake on both sides; sits between an operand source and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width (>=1).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- a  in  WIDTH  operand A (ignored when acc_en=1).
- b  in  WIDTH  operand B.
- sel  in  3  function select, sampled with the transaction.
- acc_en  in  1  use accumulator as operand A and write the result back; sampled with the transaction.
- clr_acc  in  1  clear accumulator; independent of handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- y_zero  out  1  y == 0.
- y_par  out  1  XOR-reduction of y.
- op_cnt  out  CNT_W  number of results consumed (out_valid & out_ready), wraps.

Behaviour:
- Single clock domain; reset is synchronous and active-high (clk, rst).
- Reset (rst=1 at a clk edge), all outputs/state: s1_v=0, s2_v=0, out_valid=0, y=0, y_zero=1, y_par=0, op_cnt=0, accumulator=0. rst overrides every other input in that cycle.
- Reset mid-operation drops in-flight transactions silently.
- Functions (bitwise, on A = acc_en ? acc : a):
  - 000 A&B; 001 A|B; 010 A^B; 011 ~(A^B)
  - 100 ~(A&B); 101 ~(A|B); 110 A&~B; 111 A (pass)
- Stage 1 registers a, b, sel and acc_en; s1_v marks it valid. No computation in stage 1.
- Stage 2: the function is evaluated combinationally during the s1->s2 transfer.
  - y, y_zero and y_par are registered from that result.
  - y_zero and y_par derive from the registered y, consistent with it in the same cycle.
- Handshake:
  - advance2 = !s2_v | out_ready
  - advance1 = s1_v & advance2
  - in_ready = !s1_v | advance2
  - Input accept = in_valid & in_ready. Output fire = out_valid & out_ready.
- Latency: accept at edge k -> out_valid=1 after edge k+1 (visible cycle k+1..k+2), i.e. result registered 2 edges after the operands are driven. Throughput 1/cycle with out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - y, y_zero, y_par and out_valid hold stable.
  - Stage 1 holds its contents.
  - in_ready=0 once stage 1 is full.
- Accumulator:
  - Updated only on an s1->s2 transfer whose acc_en=1: acc <= result.
  - Because computation is serialized at the transfer, back-to-back accumulate ops chain with no hazard.
  - Transactions with acc_en=0 leave acc unchanged.
- clr_acc: acc <= 0 at the edge. If an accumulate transfer occurs in the same cycle, that transfer uses the pre-clear acc value for y, and acc still ends at 0 (clear wins).
- op_cnt increments by 1 per output fire and wraps from 2^CNT_W-1 to 0.
- in_valid=0 with stage 1 empty: nothing is loaded. a, b and sel are don't-care.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, y=0, y_zero=1, op_cnt=0, acc=0 after release.
- Function sweep: out_ready=1, a=8'hC3, b=8'hA5, sel 0..7 on consecutive cycles -> y = 81, E7, 66, 99, 7E, 18, 42, C3 in order; each result 2 edges after its operands; y_par=0 for all; op_cnt=8.
- Backpressure: stream 4 ops, hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, y holds the first result; release -> remaining results in order, no loss or duplication.
- Accumulate: clr_acc pulse, then acc_en=1: sel=001 b=0F, sel=001 b=F0, sel=010 b=FF back-to-back -> y = 0F, FF, 00 with y_zero=1 on the last; a=8'h55 is ignored throughout.
- clr_acc colliding with an accumulate transfer (acc=3C, sel=001 b=01) -> y=3D; the next accumulate op sel=001 b=02 -> y=02.
- Counter wrap: CNT_W=2, 5 fires -> op_cnt sequence 1, 2, 3, 0, 1.
